// File: rtl/seg_scan2.sv
// Two-digit multiplexed seven-segment driver: commits a BCD pair at frame boundaries and
// scans it onto an active-low segment bus with blank gaps, leading-zero blanking and blink.
module seg_scan2 #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GAP          = 500,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       load,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int unsigned CntMax = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BfW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SegOff  = 7'h7F;
  localparam logic [6:0] SegDash = 7'h3F;

  typedef enum logic [1:0] {
    StBlank0,
    StShow0,
    StBlank1,
    StShow1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pend1_q, pend1_d, pend0_q, pend0_d;
  logic [3:0]      disp1_q, disp1_d, disp0_q, disp0_d;
  logic [BfW-1:0]  bcnt_q, bcnt_d;
  logic            vis_q, vis_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      dig_q, dig_d;
  logic            tick_q, tick_d;
  logic            last;
  logic            commit;
  logic            err;
  logic            lz;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CntW'(1);
    commit  = 1'b0;
    last    = (cnt_q == '0);
    if (last) begin
      unique case (state_q)
        StBlank0: begin
          state_d = StShow0;
          cnt_d   = CntW'(SCAN_DIV - 1);
        end
        StShow0: begin
          state_d = StBlank1;
          cnt_d   = CntW'(GAP - 1);
        end
        StBlank1: begin
          state_d = StShow1;
          cnt_d   = CntW'(SCAN_DIV - 1);
        end
        StShow1: begin
          state_d = StBlank0;
          cnt_d   = CntW'(GAP - 1);
          commit  = 1'b1;
        end
        default: begin
          state_d = StBlank0;
          cnt_d   = CntW'(GAP - 1);
        end
      endcase
    end
  end

  always_comb begin
    pend1_d = load ? bcd1 : pend1_q;
    pend0_d = load ? bcd0 : pend0_q;
    // The commit takes the pending pair as it stood before this edge's load.
    disp1_d = commit ? pend1_q : disp1_q;
    disp0_d = commit ? pend0_q : disp0_q;
    bcnt_d  = bcnt_q;
    vis_d   = vis_q;
    if (!blink) begin
      bcnt_d = '0;
      vis_d  = 1'b1;
    end else if (commit) begin
      if (bcnt_q == BfW'(BLINK_FRAMES - 1)) begin
        bcnt_d = '0;
        vis_d  = ~vis_q;
      end else begin
        bcnt_d = bcnt_q + BfW'(1);
      end
    end
  end

  assign err = (disp0_d == 4'hF);
  assign lz  = blank_lz && (disp1_d == 4'd0) && (disp0_d <= 4'd9);

  // Outputs are re-evaluated only on state transitions, so they hold steady within a state.
  always_comb begin
    seg_d  = seg_q;
    dig_d  = dig_q;
    tick_d = commit;
    if (last) begin
      seg_d = SegOff;
      dig_d = 2'b11;
      unique case (state_d)
        StShow0: begin
          if (vis_d) begin
            dig_d = 2'b10;
            seg_d = err ? SegDash : decode(disp0_d);
          end
        end
        StShow1: begin
          if (vis_d && !lz) begin
            dig_d = 2'b01;
            seg_d = err ? SegDash : decode(disp1_d);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank0;
      cnt_q   <= CntW'(GAP - 1);
      pend1_q <= '0;
      pend0_q <= '0;
      disp1_q <= '0;
      disp0_q <= '0;
      bcnt_q  <= '0;
      vis_q   <= 1'b1;
      seg_q   <= SegOff;
      dig_q   <= 2'b11;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend1_q <= pend1_d;
      pend0_q <= pend0_d;
      disp1_q <= disp1_d;
      disp0_q <= disp0_d;
      bcnt_q  <= bcnt_d;
      vis_q   <= vis_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan2.sv
// Directed bench for seg_scan2 with SCAN_DIV=4, GAP=1, BLINK_FRAMES=2 (10-cycle frames).
module tb_seg_scan2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd1 = 4'd0;
  logic [3:0] bcd0 = 4'd0;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  logic       blink = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  seg_scan2 #(
    .SCAN_DIV    (4),
    .GAP         (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .load      (load),
    .blank_lz  (blank_lz),
    .blink     (blink),
    .seg       (seg),
    .dig_en    (dig_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b0;
    logic       lz;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [1:0] d1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next frame_tick; afterwards we sit at frame offset 0.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    if (!frame_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick: no frame_tick within 40 cycles at %0t", $time);
    end
  endtask

  task automatic check_pos(input int off, input logic [6:0] s0, input logic [1:0] d0,
                           input logic [6:0] s1, input logic [1:0] d1);
    logic [6:0] es;
    logic [1:0] ed;
    if (off >= 1 && off <= 4) begin
      es = s0;
      ed = d0;
    end else if (off >= 6) begin
      es = s1;
      ed = d1;
    end else begin
      es = 7'h7F;
      ed = 2'b11;
    end
    check($sformatf("seg@%0d", off), {1'b0, es}, {1'b0, seg});
    check($sformatf("dig@%0d", off), {6'd0, dig_en}, {6'd0, ed});
    check($sformatf("tick@%0d", off), {7'd0, frame_tick}, {7'd0, (off == 0)});
  endtask

  task automatic check_rest(input logic [6:0] s0, input logic [1:0] d0,
                            input logic [6:0] s1, input logic [1:0] d1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check_pos(i, s0, d0, s1, d1);
    end
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [1:0] d0,
                             input logic [6:0] s1, input logic [1:0] d1);
    wait_tick();
    check_pos(0, s0, d0, s1, d1);
    check_rest(s0, d0, s1, d1);
  endtask

  task automatic release_and_time();
    int n = 0;
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    check("first_tick_cycles", 8'(n), 8'd10);
    check_pos(0, 7'h40, 2'b10, 7'h40, 2'b01);
    check_rest(7'h40, 2'b10, 7'h40, 2'b01);
    @(negedge clk);
    check("tick_period", {7'd0, frame_tick}, 8'd1);
  endtask

  initial begin
    logic [6:0] prev_s0;
    vecs[0] = '{4'h4, 4'h2, 1'b0, 7'h24, 7'h19, 2'b01};
    vecs[1] = '{4'h0, 4'h7, 1'b1, 7'h78, 7'h7F, 2'b11};
    vecs[2] = '{4'h0, 4'hF, 1'b1, 7'h3F, 7'h3F, 2'b01};
    vecs[3] = '{4'h8, 4'h8, 1'b0, 7'h00, 7'h00, 2'b01};
    vecs[4] = '{4'h0, 4'h0, 1'b0, 7'h40, 7'h40, 2'b01};
    vecs[5] = '{4'h9, 4'h3, 1'b1, 7'h30, 7'h10, 2'b01};
    vecs[6] = '{4'hC, 4'h5, 1'b0, 7'h12, 7'h3F, 2'b01};
    vecs[7] = '{4'h7, 4'hF, 1'b0, 7'h3F, 7'h3F, 2'b01};
    vecs[8] = '{4'h0, 4'hA, 1'b1, 7'h3F, 7'h40, 2'b01};
    vecs[9] = '{4'h1, 4'h6, 1'b0, 7'h02, 7'h79, 2'b01};

    // Reset and first-frame timing
    repeat (3) @(negedge clk);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_dig", {6'd0, dig_en}, 8'd3);
    check("rst_tick", {7'd0, frame_tick}, 8'd0);
    release_and_time();

    // Table: load mid-frame, old value must persist until the commit
    prev_s0 = 7'h40;
    for (int v = 0; v < 10; v++) begin
      wait_tick();
      repeat (2) @(negedge clk);
      bcd1 = vecs[v].b1;
      bcd0 = vecs[v].b0;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      blank_lz = vecs[v].lz;
      check($sformatf("v%0d_hold_seg", v), {1'b0, seg}, {1'b0, prev_s0});
      check_frame(vecs[v].s0, 2'b10, vecs[v].s1, vecs[v].d1);
      prev_s0 = vecs[v].s0;
    end
    blank_lz = 1'b0;

    // Last load in a frame wins
    wait_tick();
    @(negedge clk);
    load = 1'b1;
    bcd1 = 4'd1; bcd0 = 4'd1;
    @(negedge clk);
    bcd1 = 4'd2; bcd0 = 4'd2;
    @(negedge clk);
    bcd1 = 4'd3; bcd0 = 4'd3;
    @(negedge clk);
    load = 1'b0;
    check_frame(7'h30, 2'b10, 7'h30, 2'b01);

    // Load in the frame_tick cycle lands one frame later
    wait_tick();
    bcd1 = 4'd5; bcd0 = 4'd5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("commit_load_s0", {1'b0, seg}, 8'h30);
    for (int i = 2; i < 10; i++) begin
      @(negedge clk);
      check_pos(i, 7'h30, 2'b10, 7'h30, 2'b01);
    end
    check_frame(7'h12, 2'b10, 7'h12, 2'b01);

    // Blink: visible A,B, dark C,D, visible E,F, dark G
    wait_tick();
    bcd1 = 4'd8; bcd0 = 4'd8;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_frame(7'h00, 2'b10, 7'h00, 2'b01);
    wait_tick();
    blink = 1'b1;
    check_rest(7'h00, 2'b10, 7'h00, 2'b01);
    check_frame(7'h00, 2'b10, 7'h00, 2'b01);
    check_frame(7'h7F, 2'b11, 7'h7F, 2'b11);
    check_frame(7'h7F, 2'b11, 7'h7F, 2'b11);
    check_frame(7'h00, 2'b10, 7'h00, 2'b01);
    check_frame(7'h00, 2'b10, 7'h00, 2'b01);
    wait_tick();
    @(negedge clk);
    check_pos(1, 7'h7F, 2'b11, 7'h7F, 2'b11);
    @(negedge clk);
    blink = 1'b0;
    @(negedge clk);
    check_pos(3, 7'h7F, 2'b11, 7'h7F, 2'b11);
    for (int i = 4; i < 10; i++) begin
      @(negedge clk);
      check_pos(i, 7'h7F, 2'b11, 7'h00, 2'b01);
    end
    check_frame(7'h00, 2'b10, 7'h00, 2'b01);

    // Asynchronous reset during SHOW1
    wait_tick();
    repeat (7) @(negedge clk);
    check("pre_rst_dig", {6'd0, dig_en}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", {1'b0, seg}, 8'h7F);
    check("async_rst_dig", {6'd0, dig_en}, 8'd3);
    repeat (2) @(negedge clk);
    release_and_time();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
